// File: rtl/bus_timer_irq_if.sv
// CPU-side bus bundle for bus_timer_irq: address/write data/write enable from the core,
// read data, hit flag, ready, IRQ and NMI back to the core.
// Ports: AB[15:0], DO[7:0], WE (core -> peripheral); DI[7:0], hit_q, RDY, IRQ, NMI (peripheral -> core).
interface bus_timer_irq_if;
  logic [15:0] AB;
  logic [7:0]  DO;
  logic        WE;
  logic [7:0]  DI;
  logic        hit_q;
  logic        RDY;
  logic        IRQ;
  logic        NMI;

  modport master (output AB, DO, WE, input DI, hit_q, RDY, IRQ, NMI);
  modport slave  (input AB, DO, WE, output DI, hit_q, RDY, IRQ, NMI);
endinterface

// File: rtl/bus_timer_irq.sv
// Purpose: 6502-bus peripheral with a 16-bit down-counter timer, 4-source maskable IRQ, NMI pulser.
// Latency: reads return DI/hit_q the cycle after commit; IRQ is registered one cycle after its causes.
// Backpressure: holds RDY low for WAIT_STATES cycles per selected access, then commits.
// Ports: clk, reset (sync active-low), bus (slave modport: AB/DO/WE in, DI/hit_q/RDY/IRQ/NMI out),
//        irq_src[3:0] (synchronous level sources), nmi_req (asynchronous NMI request).
module bus_timer_irq #(
  parameter logic [15:0] BASE_ADDR   = 16'hD000,
  parameter int          WAIT_STATES = 1,
  parameter int          NMI_CYCLES  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  bus_timer_irq_if.slave        bus,
  input  logic [3:0]            irq_src,
  input  logic                  nmi_req
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam int         WS_M1_INT = (WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0;
  localparam logic [1:0] WS_M1     = WS_M1_INT[1:0];
  localparam logic [3:0] NMI_LOAD  = NMI_CYCLES[3:0];

  // Access FSM
  logic [0:0] state;
  logic [1:0] wc;
  logic       sel;
  logic [2:0] idx;
  logic       commit;
  logic       rdy;

  // Register file
  logic [15:0] rld;
  logic [15:0] count;
  logic [7:0]  snap;
  logic        en;
  logic        auto_rld;
  logic        tie;
  logic        tf;
  logic [3:0]  pend;
  logic [3:0]  mask;
  logic        reload_due;

  // NMI path
  logic       nmi_s1, nmi_s2, nmi_s3;
  logic [3:0] nmi_cnt;

  logic       wr, rd;
  logic       wr_rld_lo, wr_rld_hi, wr_ctrl, wr_status, wr_mask;
  logic       dec, tf_set;
  logic [7:0] rdata;

  assign sel = (bus.AB[15:3] == BASE_ADDR[15:3]);
  assign idx = bus.AB[2:0];

  // RDY is forced high while in reset so the core never sees a stall from a dead access.
  always_comb begin
    commit = 1'b0;
    rdy    = 1'b1;
    if (reset && sel) begin
      if (state == ST_IDLE) begin
        if (WAIT_STATES == 0) commit = 1'b1;
        else                  rdy    = 1'b0;
      end else begin
        if (wc != 2'd0) rdy    = 1'b0;
        else            commit = 1'b1;
      end
    end
  end

  assign bus.RDY = rdy;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      wc    <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sel && (WAIT_STATES != 0)) begin
            state <= ST_WAIT;
            wc    <= WS_M1;
          end
        end
        default: begin
          // Commit cycle returns to IDLE; a fresh access needs an IDLE cycle first.
          if (!sel)             state <= ST_IDLE;
          else if (wc != 2'd0)  wc    <= wc - 2'd1;
          else                  state <= ST_IDLE;
        end
      endcase
    end
  end

  assign wr        = commit & bus.WE;
  assign rd        = commit & ~bus.WE;
  assign wr_rld_lo = wr && (idx == 3'd0);
  assign wr_rld_hi = wr && (idx == 3'd1);
  assign wr_ctrl   = wr && (idx == 3'd2);
  assign wr_status = wr && (idx == 3'd3);
  assign wr_mask   = wr && (idx == 3'd4);

  // A CPU load of the counter pre-empts the decrement (and its terminal-count event).
  assign dec    = en && (count != 16'd0) && !wr_rld_hi;
  assign tf_set = dec && (count == 16'd1);

  always_comb begin
    rdata = 8'h00;
    case (idx)
      3'd0:    rdata = rld[7:0];
      3'd1:    rdata = rld[15:8];
      3'd2:    rdata = {5'b0, tie, auto_rld, en};
      3'd3:    rdata = {pend, 3'b0, tf};
      3'd4:    rdata = {mask, 4'b0};
      3'd5:    rdata = count[7:0];
      3'd6:    rdata = snap;
      default: rdata = 8'h00;
    endcase
  end

  // Timer and configuration registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      rld        <= 16'd0;
      count      <= 16'd0;
      en         <= 1'b0;
      auto_rld   <= 1'b0;
      tie        <= 1'b0;
      mask       <= 4'd0;
      reload_due <= 1'b0;
      snap       <= 8'd0;
    end else begin
      if (wr_rld_lo) rld[7:0]  <= bus.DO;
      if (wr_rld_hi) rld[15:8] <= bus.DO;

      if (wr_rld_hi)              count <= {bus.DO, rld[7:0]};
      else if (en && reload_due)  count <= rld;
      else if (dec)               count <= count - 16'd1;

      // Reload happens the cycle after the terminal count, only in AUTO mode.
      reload_due <= tf_set && auto_rld;

      if (wr_ctrl) begin
        en       <= bus.DO[0];
        auto_rld <= bus.DO[1];
        tie      <= bus.DO[2];
      end else if (tf_set && !auto_rld) begin
        en <= 1'b0;
      end

      if (wr_mask) mask <= bus.DO[7:4];

      // Reading CNT_LO freezes the high byte so a following CNT_HI read is coherent.
      if (rd && (idx == 3'd5)) snap <= count[15:8];
    end
  end

  // Status, interrupt and read-data registers. Sets win over W1C clears.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tf        <= 1'b0;
      pend      <= 4'd0;
      bus.IRQ   <= 1'b0;
      bus.DI    <= 8'h00;
      bus.hit_q <= 1'b0;
    end else begin
      tf        <= tf_set | (tf & ~(wr_status & bus.DO[0]));
      pend      <= irq_src | (pend & ~({4{wr_status}} & bus.DO[7:4]));
      bus.IRQ   <= (tf & tie) | (|(pend & mask));
      bus.DI    <= rd ? rdata : 8'h00;
      bus.hit_q <= rd;
    end
  end

  // NMI: two-flop synchronizer, rising-edge detect, retriggerable pulse counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      nmi_s1  <= 1'b0;
      nmi_s2  <= 1'b0;
      nmi_s3  <= 1'b0;
      nmi_cnt <= 4'd0;
    end else begin
      nmi_s1 <= nmi_req;
      nmi_s2 <= nmi_s1;
      nmi_s3 <= nmi_s2;
      if (nmi_s2 && !nmi_s3)    nmi_cnt <= NMI_LOAD;
      else if (nmi_cnt != 4'd0) nmi_cnt <= nmi_cnt - 4'd1;
    end
  end

  assign bus.NMI = (nmi_cnt != 4'd0);

endmodule

// File: tb/tb_bus_timer_irq.sv
// Directed bench for bus_timer_irq with WAIT_STATES=2, NMI_CYCLES=4.
// Register table vectors first, then hand-written timer / IRQ / NMI / reset sequences.
module tb_bus_timer_irq;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] irq_src;
  logic       nmi_req;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_err = 0;

  bus_timer_irq_if bus ();

  bus_timer_irq #(
    .BASE_ADDR  (16'hD000),
    .WAIT_STATES(2),
    .NMI_CYCLES (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .irq_src(irq_src),
    .nmi_req(nmi_req)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] a;
    logic        we;
    logic [7:0]  d;
    logic [7:0]  exp_rd;
    logic        exp_hit;
    int          exp_stall;
  } vec_t;

  vec_t tbl [0:15];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Runs one bus access; returns read data/hit sampled just after the commit edge.
  task automatic acc(input logic [15:0] a, input logic we, input logic [7:0] d,
                     output logic [7:0] rdat, output logic hit, output int stalls);
    bus.AB = a; bus.WE = we; bus.DO = d; stalls = 0;
    #1;
    while (bus.RDY !== 1'b1 && stalls < 16) begin
      stalls++;
      tick();
    end
    if (stalls >= 16) begin
      n_vec++; n_err++;
      $display("FAIL rdy_timeout: RDY still low after %0d cycles, expected high", stalls);
    end
    tick();
    rdat = bus.DI; hit = bus.hit_q;
    bus.AB = 16'h0000; bus.WE = 1'b0; bus.DO = 8'h00;
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    logic [7:0] r; logic h; int s;
    acc(a, 1'b1, d, r, h, s);
  endtask

  task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] exp);
    logic [7:0] r; logic h; int s;
    acc(a, 1'b0, 8'h00, r, h, s);
    check(name, {8'h00, r}, {8'h00, exp});
    check({name, "_hit"}, {15'd0, h}, 16'd1);
  endtask

  function automatic logic [7:0] auto_cnt(input int j);
    case (j % 3)
      0:       return 8'd2;
      1:       return 8'd1;
      default: return 8'd0;
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r; logic h; int s; int t0; int k; logic exp_nmi;

    tbl[0]  = '{16'hD000, 1'b1, 8'h34, 8'h00, 1'b0, 2};
    tbl[1]  = '{16'hD000, 1'b0, 8'h00, 8'h34, 1'b1, 2};
    tbl[2]  = '{16'hD001, 1'b1, 8'h12, 8'h00, 1'b0, 2};
    tbl[3]  = '{16'hD001, 1'b0, 8'h00, 8'h12, 1'b1, 2};
    tbl[4]  = '{16'hD002, 1'b1, 8'hFE, 8'h00, 1'b0, 2};
    tbl[5]  = '{16'hD002, 1'b0, 8'h00, 8'h06, 1'b1, 2};
    tbl[6]  = '{16'hD004, 1'b1, 8'hFF, 8'h00, 1'b0, 2};
    tbl[7]  = '{16'hD004, 1'b0, 8'h00, 8'hF0, 1'b1, 2};
    tbl[8]  = '{16'hD005, 1'b0, 8'h00, 8'h34, 1'b1, 2};
    tbl[9]  = '{16'hD006, 1'b0, 8'h00, 8'h12, 1'b1, 2};
    tbl[10] = '{16'hD007, 1'b1, 8'hAA, 8'h00, 1'b0, 2};
    tbl[11] = '{16'hD007, 1'b0, 8'h00, 8'h00, 1'b1, 2};
    tbl[12] = '{16'hD003, 1'b0, 8'h00, 8'h00, 1'b1, 2};
    tbl[13] = '{16'hD008, 1'b0, 8'h00, 8'h00, 1'b0, 0};
    tbl[14] = '{16'hD004, 1'b1, 8'h00, 8'h00, 1'b0, 2};
    tbl[15] = '{16'hD002, 1'b1, 8'h00, 8'h00, 1'b0, 2};

    // Reset with random inputs
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.AB = 16'($urandom); bus.DO = 8'($urandom); bus.WE = 1'($urandom);
      irq_src = 4'($urandom); nmi_req = 1'($urandom);
      tick();
    end
    check("rst_di",  {8'h00, bus.DI}, 16'h0000);
    check("rst_hit", {15'd0, bus.hit_q}, 16'd0);
    check("rst_rdy", {15'd0, bus.RDY}, 16'd1);
    check("rst_irq", {15'd0, bus.IRQ}, 16'd0);
    check("rst_nmi", {15'd0, bus.NMI}, 16'd0);
    bus.AB = 16'h0000; bus.DO = 8'h00; bus.WE = 1'b0; irq_src = 4'd0; nmi_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    rd_chk("rst_ctrl", 16'hD002, 8'h00);

    // Reset in the middle of a wait-stated write abandons it
    bus.AB = 16'hD000; bus.WE = 1'b1; bus.DO = 8'h55;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_rdy", {15'd0, bus.RDY}, 16'd1);
    tick();
    bus.AB = 16'h0000; bus.WE = 1'b0; bus.DO = 8'h00;
    reset = 1'b1;
    tick();
    rd_chk("midrst_rld", 16'hD000, 8'h00);

    // Register table
    for (int i = 0; i < 16; i++) begin
      acc(tbl[i].a, tbl[i].we, tbl[i].d, r, h, s);
      check($sformatf("vec%0d_stall", i), 16'(s), 16'(tbl[i].exp_stall));
      if (!tbl[i].we) begin
        check($sformatf("vec%0d_rd", i), {8'h00, r}, {8'h00, tbl[i].exp_rd});
        check($sformatf("vec%0d_hit", i), {15'd0, h}, {15'd0, tbl[i].exp_hit});
      end
    end

    // One-shot timer with interrupt
    wr(16'hD000, 8'h03);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h05);
    tick(); tick(); tick();
    check("oneshot_irq_early", {15'd0, bus.IRQ}, 16'd0);
    tick();
    check("oneshot_irq", {15'd0, bus.IRQ}, 16'd1);
    rd_chk("oneshot_status", 16'hD003, 8'h01);
    rd_chk("oneshot_ctrl", 16'hD002, 8'h04);
    rd_chk("oneshot_cnt", 16'hD005, 8'h00);
    wr(16'hD003, 8'h01);
    check("w1c_irq_hold", {15'd0, bus.IRQ}, 16'd1);
    tick();
    check("w1c_irq_low", {15'd0, bus.IRQ}, 16'd0);

    // Auto-reload: count cycles 2,1,0 with the reload one cycle after terminal count
    wr(16'hD000, 8'h02);
    wr(16'hD001, 8'h00);
    wr(16'hD002, 8'h03);
    t0 = cyc;
    for (int i = 0; i < 3; i++) begin
      acc(16'hD005, 1'b0, 8'h00, r, h, s);
      k = cyc - t0;
      check($sformatf("auto_cnt%0d", i), {8'h00, r}, {8'h00, auto_cnt(k - 1)});
      tick();
    end
    rd_chk("auto_snap", 16'hD006, 8'h00);
    rd_chk("auto_tf", 16'hD003, 8'h01);
    wr(16'hD002, 8'h00);
    wr(16'hD003, 8'h01);

    // External interrupt aggregation
    irq_src = 4'b0100;
    tick();
    rd_chk("agg_status", 16'hD003, 8'h40);
    check("agg_irq_masked", {15'd0, bus.IRQ}, 16'd0);
    wr(16'hD004, 8'h40);
    tick();
    check("agg_irq", {15'd0, bus.IRQ}, 16'd1);
    wr(16'hD003, 8'h40);
    rd_chk("agg_set_wins", 16'hD003, 8'h40);
    check("agg_irq_stays", {15'd0, bus.IRQ}, 16'd1);
    irq_src = 4'b0000;
    wr(16'hD003, 8'h40);
    rd_chk("agg_cleared", 16'hD003, 8'h00);
    tick();
    check("agg_irq_low", {15'd0, bus.IRQ}, 16'd0);

    // NMI single pulse: high on ticks 3..6 after the request rises
    nmi_req = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      exp_nmi = (i >= 3 && i <= 6);
      check($sformatf("nmi_t%0d", i), {15'd0, bus.NMI}, {15'd0, exp_nmi});
    end
    nmi_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // NMI retrigger: second edge reloads the counter, pulse runs ticks 3..10
    nmi_req = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      exp_nmi = (i >= 3 && i <= 10);
      check($sformatf("nmi_ext_t%0d", i), {15'd0, bus.NMI}, {15'd0, exp_nmi});
      if (i == 3) nmi_req = 1'b0;
      if (i == 4) nmi_req = 1'b1;
    end
    nmi_req = 1'b0;

    // Non-selected address
    bus.AB = 16'hD010; bus.WE = 1'b0;
    #1;
    check("nosel_rdy", {15'd0, bus.RDY}, 16'd1);
    tick();
    check("nosel_di",  {8'h00, bus.DI}, 16'h0000);
    check("nosel_hit", {15'd0, bus.hit_q}, 16'd0);
    bus.AB = 16'h0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
